sdram_ch3_arbiter: RTL and testbench

SDRAM_CH3_ARBITER -- requirements
Module: sdram_ch3_arbiter

---
 rtl/sdram_arb_pkg.sv | 24 ++
 rtl/sdram_ch3_arbiter_rr_pick.sv | 34 +++
 rtl/sdram_ch3_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sdram_ch3_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM channel-3 client arbiter.
package sdram_arb_pkg;

    localparam int NCLIENT_DEF = 4;
    localparam int TIMEOUT_DEF = 255;
    localparam int ADDR_W      = 26;
    localparam int DATA_W      = 16;
    localparam int BE_W        = 2;
    localparam int RDATA_W     = 64;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } arb_state_t;

    // Client index width, kept at least one bit for a single-client build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_ch3_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer wins.
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int N  = NCLIENT_DEF,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        int w_c;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_c     = 0;
        for (int k = 0; k < N; k++) begin
            w_c = int'(i_ptr) + k;
            if (w_c >= N) begin
                w_c = w_c - N;
            end
            if (!o_valid && i_req[w_c]) begin
                o_valid     = 1'b1;
                o_idx       = IW'(w_c);
                o_grant[w_c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_ch3_arbiter.sv
// Arbitrates NCLIENT word-access clients onto SDRAM channel 3, one transaction at a time,
// with a WAIT timeout and a two-cycle request-low gap so the controller sees every edge.
module sdram_ch3_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NCLIENT = NCLIENT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           init_n,
    input  logic [NCLIENT-1:0]             cl_req,
    input  logic [NCLIENT-1:0]             cl_rnw,
    input  logic [NCLIENT-1:0][ADDR_W:1]   cl_addr,
    input  logic [NCLIENT-1:0][DATA_W-1:0] cl_din,
    input  logic [NCLIENT-1:0][BE_W-1:0]   cl_be,
    output logic [NCLIENT-1:0]             cl_ack,
    output logic                           cl_err,
    output logic [RDATA_W-1:0]             cl_dout,
    output logic                           sd_req,
    output logic                           sd_rnw,
    output logic [ADDR_W:1]                sd_addr,
    output logic [DATA_W-1:0]              sd_din,
    output logic [BE_W-1:0]                sd_be,
    input  logic                           sd_ready,
    input  logic [RDATA_W-1:0]             sd_dout
);

    localparam int             IW       = idx_width(NCLIENT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NCLIENT - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [IW-1:0]       r_rr_ptr;
    logic [NCLIENT-1:0]  r_gnt;
    logic [NCLIENT-1:0]  r_ack;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_gap;
    logic [RDATA_W-1:0]  r_dout;
    logic                r_sd_rnw;
    logic [ADDR_W:1]     r_sd_addr;
    logic [DATA_W-1:0]   r_sd_din;
    logic [BE_W-1:0]     r_sd_be;

    logic [NCLIENT-1:0]  w_grant;
    logic [IW-1:0]       w_idx;
    logic                w_valid;
    logic                w_done;
    logic                w_expire;

    rr_pick #(
        .N  (NCLIENT),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (cl_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // A completion in the last permitted WAIT cycle beats the timeout.
    assign w_done   = (r_state == ST_WAIT) && sd_ready;
    assign w_expire = (r_state == ST_WAIT) && !sd_ready && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!init_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        sd_req       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sd_req       = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                sd_req = 1'b1;
                if (w_done || w_expire) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_gap     <= 1'b0;
            r_dout    <= '0;
            r_sd_rnw  <= 1'b0;
            r_sd_addr <= '0;
            r_sd_din  <= '0;
            r_sd_be   <= '0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt     <= w_grant;
                        r_rr_ptr  <= (w_idx == IDX_LAST) ? '0 : w_idx + 1'b1;
                        r_sd_rnw  <= cl_rnw[w_idx];
                        r_sd_addr <= cl_addr[w_idx];
                        r_sd_din  <= cl_din[w_idx];
                        r_sd_be   <= cl_be[w_idx];
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_ack <= r_gnt;
                        r_gap <= 1'b0;
                        if (r_sd_rnw) begin
                            r_dout <= sd_dout;
                        end
                    end else if (w_expire) begin
                        r_ack <= r_gnt;
                        r_err <= 1'b1;
                        r_gap <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_gap <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cl_ack  = r_ack;
    assign cl_err  = r_err;
    assign cl_dout = r_dout;
    assign sd_rnw  = r_sd_rnw;
    assign sd_addr = r_sd_addr;
    assign sd_din  = r_sd_din;
    assign sd_be   = r_sd_be;

endmodule

// File: tb/tb_sdram_ch3_arbiter.sv
// Bench for sdram_ch3_arbiter: transaction-timeline reference model checked every cycle,
// directed scenarios with hand-computed expectations, then a randomized phase.
module tb_sdram_ch3_arbiter;

    localparam int N  = 4;
    localparam int TO = 255;

    logic                 clk;
    logic                 init_n;
    logic [N-1:0]         cl_req;
    logic [N-1:0]         cl_rnw;
    logic [N-1:0][26:1]   cl_addr;
    logic [N-1:0][15:0]   cl_din;
    logic [N-1:0][1:0]    cl_be;
    logic [N-1:0]         cl_ack;
    logic                 cl_err;
    logic [63:0]          cl_dout;
    logic                 sd_req;
    logic                 sd_rnw;
    logic [26:1]          sd_addr;
    logic [15:0]          sd_din;
    logic [1:0]           sd_be;
    logic                 sd_ready;
    logic [63:0]          sd_dout;

    sdram_ch3_arbiter #(.NCLIENT(N), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .init_n   (init_n),
        .cl_req   (cl_req),
        .cl_rnw   (cl_rnw),
        .cl_addr  (cl_addr),
        .cl_din   (cl_din),
        .cl_be    (cl_be),
        .cl_ack   (cl_ack),
        .cl_err   (cl_err),
        .cl_dout  (cl_dout),
        .sd_req   (sd_req),
        .sd_rnw   (sd_rnw),
        .sd_addr  (sd_addr),
        .sd_din   (sd_din),
        .sd_be    (sd_be),
        .sd_ready (sd_ready),
        .sd_dout  (sd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time. A grant decided in cycle k raises
    // sd_req in k+1; the first sd_ready after the issue cycle (or TO cycles after it)
    // ends it, the ack shows one cycle later, and the next decision is 3 cycles after the end.
    bit          m_active    = 0;
    int          m_issue     = 0;
    int          m_decide_at = 0;
    int          m_ack_at    = -1;
    int          m_ptr       = 0;
    int          m_cl        = 0;
    logic [N-1:0] m_ack_vec  = '0;
    logic        m_ack_err   = 1'b0;
    logic [63:0] m_dout      = '0;
    logic        m_rnw;
    logic [26:1] m_addr;
    logic [15:0] m_din;
    logic [1:0]  m_be;
    logic        m_exp_req;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            m_exp_req = m_active && (cyc >= m_issue);
            check("sd_req", sd_req, m_exp_req);
            check("cl_ack", cl_ack, (cyc == m_ack_at) ? m_ack_vec : 4'b0000);
            check("cl_err", cl_err, (cyc == m_ack_at) ? m_ack_err : 1'b0);
            check("cl_dout", cl_dout, m_dout);
            if (m_exp_req) begin
                check("sd_rnw", sd_rnw, m_rnw);
                check("sd_addr", sd_addr, m_addr);
                check("sd_din", sd_din, m_din);
                check("sd_be", sd_be, m_be);
            end
        end
        if (!init_n) begin
            m_active    = 0;
            m_ptr       = 0;
            m_dout      = '0;
            m_ack_at    = -1;
            m_decide_at = cyc + 1;
        end else if (!m_active) begin
            if (cyc >= m_decide_at && cl_req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_active && cl_req[(m_ptr + k) % N]) begin
                        m_active = 1;
                        m_cl     = (m_ptr + k) % N;
                    end
                end
                m_ptr   = (m_cl + 1) % N;
                m_issue = cyc + 1;
                m_rnw   = cl_rnw[m_cl];
                m_addr  = cl_addr[m_cl];
                m_din   = cl_din[m_cl];
                m_be    = cl_be[m_cl];
            end
        end else if (cyc > m_issue) begin
            if (sd_ready || (cyc - m_issue == TO)) begin
                m_active    = 0;
                m_ack_at    = cyc + 1;
                m_ack_vec   = 4'(1 << m_cl);
                m_ack_err   = !sd_ready;
                m_decide_at = cyc + 3;
                if (sd_ready && m_rnw) m_dout = sd_dout;
            end
        end
    end

    // Stimulus state and observations.
    int           rdy_mode  = 2;   // -1 withhold, 0 random 1..6, >0 fixed delay
    int           rdy_at    = -1;
    bit           prev_sdreq = 0;
    bit           extra_rdy = 0;
    bit           spur_en   = 0;
    bit           rand_mode = 0;
    bit           dout_fixed = 0;
    logic [63:0]  dout_val  = '0;
    logic [N-1:0] hold      = '0;
    int           n_ack = 0, n_rise = 0, last_rise = 0, last_ack_cyc = 0;
    logic [N-1:0] last_ack;
    logic         last_err;
    logic [63:0]  ack_dout;
    logic         rise_rnw;
    logic [26:1]  rise_addr;
    logic [15:0]  rise_din;
    logic [1:0]   rise_be;
    int           ack_log[$];
    int           rise_log[$];

    function automatic int ack_i(input int i);
        if (i < ack_log.size()) return ack_log[i];
        return -1;
    endfunction

    function automatic int rise_i(input int i);
        if (i < rise_log.size()) return rise_log[i];
        return -1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (sd_req && !prev_sdreq) begin
            n_rise++;
            last_rise = cyc;
            rise_log.push_back(cyc);
            rise_rnw  = sd_rnw;
            rise_addr = sd_addr;
            rise_din  = sd_din;
            rise_be   = sd_be;
            if (rdy_mode < 0)       rdy_at = -1;
            else if (rdy_mode == 0) rdy_at = cyc + $urandom_range(1, 6);
            else                    rdy_at = cyc + rdy_mode;
        end
        prev_sdreq = sd_req;
        if (cl_ack != '0) begin
            n_ack++;
            last_ack_cyc = cyc;
            last_ack     = cl_ack;
            last_err     = cl_err;
            ack_dout     = cl_dout;
            for (int i = 0; i < N; i++) begin
                if (cl_ack[i]) begin
                    ack_log.push_back(i);
                    if (!hold[i]) cl_req[i] = 1'b0;
                end
            end
        end
        sd_ready = (cyc == rdy_at) || extra_rdy || (spur_en && $urandom_range(0, 9) == 0);
        sd_dout  = dout_fixed ? dout_val : {$urandom, $urandom};
        if (rand_mode) begin
            cl_req = 4'($urandom);
            cl_rnw = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                cl_addr[i] = 26'($urandom);
                cl_din[i]  = 16'($urandom);
                cl_be[i]   = 2'($urandom);
            end
            init_n = ($urandom_range(0, 299) != 0);
        end
    endtask

    task automatic wait_acks(input int cnt, input int bound, input string name);
        int target;
        int t;
        target = n_ack + cnt;
        t = 0;
        while (n_ack < target && t < bound) begin
            tick();
            t++;
        end
        if (n_ack < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: ack count %0d, required %0d within %0d cycles", name, n_ack, target, bound);
        end
    endtask

    task automatic wait_rise(input int bound, input string name);
        int target;
        int t;
        target = n_rise + 1;
        t = 0;
        while (n_rise < target && t < bound) begin
            tick();
            t++;
        end
        if (n_rise < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: sd_req rise count %0d, required %0d within %0d cycles", name, n_rise, target, bound);
        end
    endtask

    task automatic reset_in_wait(input int c);
        int base;
        rdy_mode = -1;
        cl_req   = 4'(1 << c);
        wait_rise(20, "rst_rise");
        repeat (2) tick();
        base   = n_ack;
        init_n = 1'b0;
        cl_req = '0;
        tick();
        init_n = 1'b1;
        check("rst_wait_sd_req_low", sd_req, 1'b0);
        repeat (20) tick();
        check("rst_wait_no_ack", n_ack - base, 0);
    endtask

    initial begin
        int base;
        bit found;
        init_n   = 1'b0;
        cl_req   = '0;
        cl_rnw   = '0;
        cl_addr  = '0;
        cl_din   = '0;
        cl_be    = '0;
        sd_ready = 1'b0;
        sd_dout  = '0;
        repeat (3) tick();
        init_n = 1'b1;
        tick();
        check("rst_sd_req", sd_req, 1'b0);
        check("rst_sd_addr", sd_addr, 26'h0);
        check("rst_sd_din", sd_din, 16'h0);
        check("rst_sd_be", sd_be, 2'b00);
        check("rst_cl_dout", cl_dout, 64'h0);

        // All four clients read at once: rotation from pointer 0.
        rdy_mode   = 2;
        dout_fixed = 1;
        dout_val   = 64'hA5A5_0000_1111_2222;
        cl_rnw     = 4'hF;
        for (int i = 0; i < N; i++) cl_addr[i] = 26'(i * 16 + 5);
        ack_log.delete();
        rise_log.delete();
        cl_req = 4'hF;
        wait_acks(4, 100, "all4_acks");
        for (int i = 0; i < N; i++) check("all4_order", ack_i(i), i);
        check("all4_spacing", rise_i(1) - rise_i(0), 6);
        check("all4_err", last_err, 1'b0);
        repeat (5) tick();

        // Client 2 write, ready 3 cycles after sd_req.
        rdy_mode   = 3;
        cl_rnw[2]  = 1'b0;
        cl_addr[2] = 26'h0001234;
        cl_din[2]  = 16'hBEEF;
        cl_be[2]   = 2'b01;
        cl_req     = 4'b0100;
        wait_acks(1, 50, "wr2_ack");
        check("wr2_rnw", rise_rnw, 1'b0);
        check("wr2_addr", rise_addr, 26'h0001234);
        check("wr2_din", rise_din, 16'hBEEF);
        check("wr2_be", rise_be, 2'b01);
        check("wr2_ack_vec", last_ack, 4'b0100);
        check("wr2_err", last_err, 1'b0);
        check("wr2_latency", last_ack_cyc - last_rise, 4);
        check("wr2_dout_kept", ack_dout, 64'hA5A5_0000_1111_2222);
        repeat (5) tick();

        // Client 1 read returns a known word.
        rdy_mode  = 2;
        dout_val  = 64'h0123_4567_89AB_CDEF;
        cl_rnw[1] = 1'b1;
        cl_req    = 4'b0010;
        wait_acks(1, 50, "rd1_ack");
        check("rd1_ack_vec", last_ack, 4'b0010);
        check("rd1_dout", ack_dout, 64'h0123_4567_89AB_CDEF);
        check("rd1_err", last_err, 1'b0);
        repeat (5) tick();

        // Withheld ready: timeout after 255 WAIT cycles, late readies ignored.
        rdy_mode  = -1;
        cl_rnw[0] = 1'b0;
        cl_req    = 4'b0001;
        wait_acks(1, 400, "to_ack");
        check("to_err", last_err, 1'b1);
        check("to_ack_vec", last_ack, 4'b0001);
        check("to_latency", last_ack_cyc - last_rise, TO + 1);
        check("to_dout_kept", ack_dout, 64'h0123_4567_89AB_CDEF);
        base = n_ack;
        extra_rdy = 1; tick();
        extra_rdy = 0; tick();
        extra_rdy = 1; tick();
        extra_rdy = 0;
        repeat (4) tick();
        check("to_late_ready_ignored", n_ack - base, 0);
        rdy_mode = 1;
        cl_req   = 4'b0001;
        wait_acks(1, 50, "to_next_ack");
        check("to_next_err", last_err, 1'b0);
        check("to_next_ack_vec", last_ack, 4'b0001);
        repeat (5) tick();

        // Reset during WAIT abandons the transaction and rewinds the pointer.
        reset_in_wait(3);
        reset_in_wait(1);
        rdy_mode = 1;
        ack_log.delete();
        rise_log.delete();
        cl_req = 4'hF;
        wait_acks(4, 100, "post_rst_acks");
        check("post_rst_first", ack_i(0), 0);
        check("post_rst_second", ack_i(1), 1);
        check("min_spacing", rise_i(1) - rise_i(0), 5);
        repeat (5) tick();

        // Client 0 hogs, client 1 asks once.
        hold[0] = 1'b1;
        ack_log.delete();
        cl_req = 4'b0011;
        wait_acks(2, 50, "fair_acks");
        found = (ack_i(0) == 1) || (ack_i(1) == 1);
        check("fair_c1_served", found, 1'b1);
        hold   = '0;
        cl_req = '0;
        repeat (10) tick();

        // Randomized traffic with spurious readies and occasional resets.
        rdy_mode   = 0;
        dout_fixed = 0;
        spur_en    = 1;
        rand_mode  = 1;
        repeat (3000) tick();
        rand_mode = 0;
        spur_en   = 0;
        init_n    = 1'b1;
        cl_req    = '0;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
